script_fetch: RTL
=================

// Module: script_fetch
// PURPOSE
//  Fetch stage feeding AnalyseScript: reads one 16-bit script word from the byte-wide,
//  synchronous-read script memory at a requested pc and presents it with a valid/ready handshake.
//  Assembles byte(pc) -> instr[7:0] (op_code/func/i_sign) and byte(pc+1) -> instr[15:8] (i_num).
//  Flags halt word (16'h0000) and misaligned (odd) pc.
// PARAMETERS
//  ADDR_W   8         script memory address width; pc width
//  HALT_WORD 16'h0000 word that raises halted
// PORTS
//  clk          in   1       system clock, rising edge
//  res          in   1       asynchronous active-low reset
//  pc_in        in   ADDR_W  byte address of word to fetch
//  pc_load      in   1       strobe: start fetch at pc_in (sampled on clk edge)
//  mem_addr     out  ADDR_W  registered address to script memory
//  mem_rdata    in   8       memory data; valid the cycle after mem_addr is sampled by memory
//  instr        out  16      assembled script word; stable while instr_valid=1
//  instr_valid  out  1       word available
//  instr_ready  in   1       consumer accepts word when instr_valid & instr_ready at clk edge
//  busy         out  1       1 in RD_LO/RD_HI/CAP_HI
//  halted       out  1       sticky: last delivered word == HALT_WORD
//  misaligned   out  1       sticky: pc_load with pc_in[0]=1
// BEHAVIOUR
//  Reset (res=0, async): state=IDLE, mem_addr=0, instr=0, instr_valid=0, busy=0, halted=0, misaligned=0.
//  FSM: IDLE -> RD_LO -> RD_HI -> CAP_HI -> VALID.
//   IDLE:   on pc_load & ~pc_in[0]: fa<=pc_in, mem_addr<=pc_in, halted<=0, misaligned<=0 -> RD_LO.
//           on pc_load & pc_in[0]: misaligned<=1, halted<=0, stay IDLE, no memory access.
//   RD_LO:  mem_addr<=fa+1 (mod 2^ADDR_W, 8'hFF+1=8'h00) -> RD_HI.
//   RD_HI:  lo<=mem_rdata -> CAP_HI.
//   CAP_HI: instr<={mem_rdata,lo}; instr_valid<=1; halted<=({mem_rdata,lo}==HALT_WORD) -> VALID.
//   VALID:  hold instr/instr_valid until instr_valid&instr_ready; then instr_valid<=0 -> IDLE
//           (or auto-fetch, see CONFIGURATION). instr not cleared on accept.
//  Latency: pc_load sampled at edge E -> instr_valid=1 after edge E+3; one word per >=4 cycles.
//  pc_load during RD_LO/RD_HI/CAP_HI: abort, discard partial bytes, restart at new pc_in
//   (same rules as IDLE); instr_valid stays 0.
//  pc_load in VALID: drops current word (instr_valid<=0) even if instr_ready same cycle
//   (accept counts as taken; consumer must not rely on both); restart at new pc_in.
//  pc_load in VALID/busy with odd pc_in: abort to IDLE, instr_valid<=0, misaligned<=1.
//  halted/misaligned clear only on next legal pc_load or reset; halt word is still delivered once.
//  Reset mid-fetch: immediate return to reset values; no word emitted.
// CONFIGURATION
//  SCRIPT_PREFETCH_EN defined: on accept in VALID with halted=0, fa<=fa+2 (wraps mod 2^ADDR_W),
//   mem_addr<=fa+2, -> RD_LO (sequential auto-fetch, no pc_load needed). halted=1 -> IDLE.
//   pc_load in same cycle as accept takes priority over auto-fetch.
//  Undefined: after accept always -> IDLE; each word needs pc_load.
// TESTING
//  Reset: res=0 mid-RD_HI -> all outputs 0, state IDLE next cycle; no instr_valid.
//  mem[0x10]=8'h21, mem[0x11]=8'h05, pc_load pc_in=0x10 at edge E -> instr=16'h0521,
//   instr_valid=1 after E+3, held 5 cycles with instr_ready=0, drops 1 cycle after ready=1.
//  Wrap: pc_in=0xFE -> mem_addr sequence 0xFE,0xFF; with SCRIPT_PREFETCH_EN next fetch at 0x00.
//  Abort: pc_load 0x10 then pc_load 0x20 one cycle later -> only word from 0x20/0x21 delivered.
//  Misaligned: pc_in=0x11 -> misaligned=1, busy=0, mem_addr unchanged; pc_load 0x12 clears it.
//  Halt: mem[0x30..0x31]=0x00 -> instr=16'h0000, halted=1; with SCRIPT_PREFETCH_EN no fetch
//   after accept (busy stays 0).

Source files
------------

// File: rtl/script_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : script_fetch
//  Description : Fetch stage for AnalyseScript. Reads one 16-bit script word
//                from the byte-wide synchronous-read script memory as two
//                byte reads (pc -> instr[7:0], pc+1 -> instr[15:8]). The word
//                is presented on a valid/ready handshake. The block flags the
//                halt word and odd (misaligned) fetch addresses.
//  Option      : SCRIPT_PREFETCH_EN - once a non-halt word is accepted, the
//                block fetches the next sequential word without a pc_load.
//  Revision    : 1.0 - initial release
// ============================================================================
module script_fetch #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              res,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_load,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              halted,
  output logic              misaligned
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_LO  = 3'd1,
    S_RD_HI  = 3'd2,
    S_CAP_HI = 3'd3,
    S_VALID  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fa;
  logic [7:0]        r_lo;

  state_t            w_state;
  logic [ADDR_W-1:0] w_fa;
  logic [7:0]        w_lo;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [15:0]       w_instr;
  logic              w_instr_valid;
  logic              w_halted;
  logic              w_misaligned;
  logic [15:0]       w_word;
  logic              w_accept;

  // The high byte arrives on mem_rdata in CAP_HI; the low byte was latched in RD_HI.
  assign w_word   = {mem_rdata, r_lo};
  assign w_accept = instr_valid & instr_ready;
  assign busy     = (r_state == S_RD_LO) || (r_state == S_RD_HI) || (r_state == S_CAP_HI);

  // Next-state and next-output logic; pc_load overrides whatever the FSM is doing.
  always_comb begin
    w_state       = r_state;
    w_fa          = r_fa;
    w_lo          = r_lo;
    w_mem_addr    = mem_addr;
    w_instr       = instr;
    w_instr_valid = instr_valid;
    w_halted      = halted;
    w_misaligned  = misaligned;

    if (pc_load) begin
      // Any load discards a partial fetch or a held word.
      w_halted      = 1'b0;
      w_instr_valid = 1'b0;
      if (pc_in[0]) begin
        // Odd address: flag it and do not touch memory.
        w_misaligned = 1'b1;
        w_state      = S_IDLE;
      end else begin
        w_misaligned = 1'b0;
        w_fa         = pc_in;
        w_mem_addr   = pc_in;
        w_state      = S_RD_LO;
      end
    end else begin
      case (r_state)
        S_RD_LO: begin
          w_mem_addr = r_fa + ADDR_W'(1);
          w_state    = S_RD_HI;
        end
        S_RD_HI: begin
          w_lo    = mem_rdata;
          w_state = S_CAP_HI;
        end
        S_CAP_HI: begin
          w_instr       = w_word;
          w_instr_valid = 1'b1;
          w_halted      = (w_word == HALT_WORD);
          w_state       = S_VALID;
        end
        S_VALID: begin
          if (w_accept) begin
            // instr is left as-is after the consumer takes it.
            w_instr_valid = 1'b0;
`ifdef SCRIPT_PREFETCH_EN
            if (!halted) begin
              w_fa       = r_fa + ADDR_W'(2);
              w_mem_addr = r_fa + ADDR_W'(2);
              w_state    = S_RD_LO;
            end else begin
              w_state = S_IDLE;
            end
`else
            w_state = S_IDLE;
`endif
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state     <= S_IDLE;
      r_fa        <= '0;
      r_lo        <= 8'h00;
      mem_addr    <= '0;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_fa        <= w_fa;
      r_lo        <= w_lo;
      mem_addr    <= w_mem_addr;
      instr       <= w_instr;
      instr_valid <= w_instr_valid;
      halted      <= w_halted;
      misaligned  <= w_misaligned;
    end
  end

endmodule
`default_nettype wire
